// File: rtl/grf_scoreboard.sv
// grf_scoreboard: tracks the newest in-flight producer of each GPR and
// derives the D-stage stall and per-operand forwarding source.
module grf_scoreboard #(
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int BUSY_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic [TW-1:0]     id_tuse_rs,
  input  logic [TW-1:0]     id_tuse_rt,
  input  logic              id_wr_en,
  input  logic [AW-1:0]     id_wr_addr,
  input  logic [TW-1:0]     id_tnew,
  input  logic              id_mdu_use,
  input  logic [BUSY_W-1:0] mdu_busy,
  input  logic              e_kill,
  output logic              stall_d,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic [(1<<AW)-1:0] pend_vec
);

  localparam int NR = 1 << AW;

  localparam logic [1:0] AGE_E = 2'd1;
  localparam logic [1:0] AGE_W = 2'd3;

  logic [NR-1:0]          valid_q;
  logic [NR-1:0]          valid_d;
  logic [NR-1:0][1:0]     age_q;
  logic [NR-1:0][1:0]     age_d;
  logic [NR-1:0][TW-1:0]  rem_q;
  logic [NR-1:0][TW-1:0]  rem_d;

  logic          chk_rs;
  logic          chk_rt;
  logic          haz_rs;
  logic          haz_rt;
  logic          mdu_hold;
  logic          issue;
  logic [TW-1:0] rem_rs;
  logic [TW-1:0] rem_rt;

  // Operand lookup against the tracked producer of each source register.
  always_comb begin
    rem_rs = rem_q[id_rs];
    rem_rt = rem_q[id_rt];
    chk_rs = id_valid && (id_rs != '0) &&
             (id_tuse_rs != '1) && valid_q[id_rs];
    chk_rt = id_valid && (id_rt != '0) &&
             (id_tuse_rt != '1) && valid_q[id_rt];
    haz_rs = chk_rs && (rem_rs > id_tuse_rs);
    haz_rt = chk_rt && (rem_rt > id_tuse_rt);
    fwd_rs = (chk_rs && rem_rs == '0) ? age_q[id_rs] : 2'd0;
    fwd_rt = (chk_rt && rem_rt == '0) ? age_q[id_rt] : 2'd0;
  end

  assign mdu_hold = id_valid && id_mdu_use && (mdu_busy != '0);
  assign stall_d  = haz_rs || haz_rt || mdu_hold;
  assign issue    = id_valid && !stall_d && id_wr_en &&
                    (id_wr_addr != '0);
  assign pend_vec = valid_q;

  // Age every entry one stage; a fresh issue then overrides its slot.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    rem_d   = rem_q;
    for (int i = 1; i < NR; i++) begin
      if (valid_q[i]) begin
        if (e_kill && age_q[i] == AGE_E) begin
          valid_d[i] = 1'b0;
        end else if (age_q[i] == AGE_W) begin
          valid_d[i] = 1'b0;
        end else begin
          age_d[i] = age_q[i] + 2'd1;
          rem_d[i] = (rem_q[i] == '0) ? '0 : rem_q[i] - 1'b1;
        end
      end
    end
    if (issue) begin
      valid_d[id_wr_addr] = 1'b1;
      age_d[id_wr_addr]   = AGE_E;
      rem_d[id_wr_addr]   = id_tnew;
    end
    valid_d[0] = 1'b0;
    age_d[0]   = 2'd0;
    rem_d[0]   = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      age_q   <= '0;
      rem_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed hazard/forwarding scenarios with
// hand-derived expected stall, forward and pending values.
module tb_grf_scoreboard;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [1:0]  id_tuse_rs;
  logic [1:0]  id_tuse_rt;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic [1:0]  id_tnew;
  logic        id_mdu_use;
  logic [2:0]  mdu_busy;
  logic        e_kill;
  logic        stall_d;
  logic [1:0]  fwd_rs;
  logic [1:0]  fwd_rt;
  logic [31:0] pend_vec;

  int n_checks = 0;
  int n_errors = 0;

  grf_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_tuse_rs (id_tuse_rs),
    .id_tuse_rt (id_tuse_rt),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_tnew    (id_tnew),
    .id_mdu_use (id_mdu_use),
    .mdu_busy   (mdu_busy),
    .e_kill     (e_kill),
    .stall_d    (stall_d),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .pend_vec   (pend_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one D-stage instruction at the negedge; outputs settle by #1.
  task automatic step(input logic v,
                      input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt,
                      input logic we, input logic [4:0] wa,
                      input logic [1:0] tn,
                      input logic mu, input logic [2:0] busy,
                      input logic kill);
    @(negedge clk);
    id_valid   = v;
    id_rs      = rs;
    id_tuse_rs = trs;
    id_rt      = rt;
    id_tuse_rt = trt;
    id_wr_en   = we;
    id_wr_addr = wa;
    id_tnew    = tn;
    id_mdu_use = mu;
    mdu_busy   = busy;
    e_kill     = kill;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [1:0] tn);
    step(1, 0, 3, 0, 3, 1, wa, tn, 0, 0, 0);
  endtask

  task automatic drain(input string tag);
    idle();
    idle();
    idle();
    check(tag, pend_vec, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0;
    id_tuse_rs = 3; id_tuse_rt = 3;
    id_wr_en = 0; id_wr_addr = 0; id_tnew = 0;
    id_mdu_use = 0; mdu_busy = 0; e_kill = 0;
    #2;
    check("rst_pend", pend_vec, 32'h0);
    check("rst_stall", {31'b0, stall_d}, 32'd0);
    check("rst_fwd", {28'b0, fwd_rs, fwd_rt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // lw $8 then a tuse=1 consumer: one stall, then no forward yet
    wr(5'd8, 2'd2);
    check("t1_issue_stall", {31'b0, stall_d}, 32'd0);
    step(1, 8, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t1_stall", {31'b0, stall_d}, 32'd1);
    check("t1_pend", pend_vec, 32'h0000_0100);
    step(1, 8, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t1_release", {31'b0, stall_d}, 32'd0);
    check("t1_fwd", {30'b0, fwd_rs}, 32'd0);
    drain("t1_drain");

    // addu $9 then beq reading $9 on both operands at tuse=0
    wr(5'd9, 2'd1);
    step(1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    check("t2_stall", {31'b0, stall_d}, 32'd1);
    step(1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    check("t2_release", {31'b0, stall_d}, 32'd0);
    check("t2_fwd_rs", {30'b0, fwd_rs}, 32'd2);
    check("t2_fwd_rt", {30'b0, fwd_rt}, 32'd2);
    drain("t2_drain");

    // jal $31 then jr $31; D then held by the MDU while the link ages
    wr(5'd31, 2'd0);
    step(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t3_nostall", {31'b0, stall_d}, 32'd0);
    check("t3_fwd_e", {30'b0, fwd_rs}, 32'd1);
    step(1, 31, 0, 0, 3, 0, 0, 0, 1, 3'b001, 0);
    check("t3_hold", {31'b0, stall_d}, 32'd1);
    check("t3_fwd_m", {30'b0, fwd_rs}, 32'd2);
    step(1, 31, 0, 0, 3, 0, 0, 0, 1, 3'b001, 0);
    check("t3_fwd_w", {30'b0, fwd_rs}, 32'd3);
    step(1, 31, 0, 0, 3, 0, 0, 0, 1, 3'b001, 0);
    check("t3_fwd_grf", {30'b0, fwd_rs}, 32'd0);
    check("t3_pend31", {31'b0, pend_vec[31]}, 32'd0);
    drain("t3_drain");

    // Back-to-back writes to $5: only the younger one is tracked
    wr(5'd5, 2'd1);
    wr(5'd5, 2'd1);
    step(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t4_nostall", {31'b0, stall_d}, 32'd0);
    check("t4_fwd_e", {30'b0, fwd_rs}, 32'd0);
    check("t4_pend", pend_vec, 32'h0000_0020);
    step(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t4_fwd_young", {30'b0, fwd_rs}, 32'd2);
    step(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t4_fwd_w", {30'b0, fwd_rs}, 32'd3);
    step(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t4_fwd_done", {30'b0, fwd_rs}, 32'd0);
    check("t4_pend_done", pend_vec, 32'h0);
    wr(5'd0, 2'd2);
    idle();
    check("t4_zero_dest", pend_vec, 32'h0);

    // Unused operand (tuse=3) never stalls on a pending load
    wr(5'd7, 2'd2);
    step(1, 7, 3, 7, 3, 0, 0, 0, 0, 0, 0);
    check("tuse3_stall", {31'b0, stall_d}, 32'd0);
    check("tuse3_fwd", {28'b0, fwd_rs, fwd_rt}, 32'd0);
    drain("tuse3_drain");

    // MDU busy holds D for exactly the busy cycles
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 3, 0, 3, 0, 0, 0, 1, 3'b010, 0);
      check($sformatf("t5_mdu%0d", i), {31'b0, stall_d}, 32'd1);
    end
    step(1, 0, 3, 0, 3, 0, 0, 0, 1, 3'b000, 0);
    check("t5_mdu_free", {31'b0, stall_d}, 32'd0);

    // Kill the load in E; a same-cycle issue still lands
    wr(5'd10, 2'd2);
    step(1, 0, 3, 0, 3, 1, 12, 1, 0, 0, 1);
    check("t5_kill_pend", pend_vec, 32'h0000_0400);
    step(1, 10, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t5_kill_nostall", {31'b0, stall_d}, 32'd0);
    check("t5_kill_fwd", {30'b0, fwd_rs}, 32'd0);
    check("t5_kill_issue", pend_vec, 32'h0000_1000);
    drain("t5_drain");

    // Async reset with E/M/W all occupied
    wr(5'd1, 2'd1);
    wr(5'd2, 2'd1);
    wr(5'd3, 2'd1);
    step(1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    check("t6_full", pend_vec, 32'h0000_000e);
    check("t6_stall", {31'b0, stall_d}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_pend", pend_vec, 32'h0);
    check("t6_rst_stall", {31'b0, stall_d}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    check("t6_after", pend_vec, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
